// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the GATE execute stage:
//   - alu_op_e   : ALUOp encodings (ALU_ADD .. ALU_SLT)
//   - NB_*       : numBits selector codes, IMM_FW_* : matching field widths
//   - flags_t    : packed {ovf, neg, zero} flag word, FLAG_* bit indices
// -----------------------------------------------------------------------------
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRA = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // numBits selector codes and the immediate field width each one picks.
    localparam logic [1:0] NB_4  = 2'd0;
    localparam logic [1:0] NB_6  = 2'd1;
    localparam logic [1:0] NB_8  = 2'd2;
    localparam logic [1:0] NB_12 = 2'd3;

    localparam int IMM_FW_4  = 4;
    localparam int IMM_FW_6  = 6;
    localparam int IMM_FW_8  = 8;
    localparam int IMM_FW_12 = 12;

    // Bit positions inside the 3-bit flags output.
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 2;

    // Field order matches FLAG_* (ovf is the MSB, zero the LSB).
    typedef struct packed {
        logic ovf;
        logic neg;
        logic zero;
    } flags_t;

endpackage

// File: rtl/exec_alu.sv
// -----------------------------------------------------------------------------
// exec_alu
// Purely combinational ALU for the execute stage.
// Ports:
//   op_i      : operation (alu_op_e)
//   a_i, b_i  : WIDTH-bit operands, treated as signed where it matters
//   result_o  : WIDTH-bit result, wraps modulo 2^WIDTH
//   flags_o   : {ovf, neg, zero}; ovf only meaningful for add/sub
// -----------------------------------------------------------------------------
module exec_alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  alu_op_e            op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   result_o,
    output flags_t             flags_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             ovf;

    // Shifts only look at the low log2(WIDTH) bits of the second operand.
    assign shamt = b_i[SHW-1:0];
    assign sum   = a_i + b_i;
    assign diff  = a_i - b_i;

    // NOTE: every variable written here is given a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        result_o = '0;
        ovf      = 1'b0;
        unique case (op_i)
            ALU_ADD: begin
                result_o = sum;
                // Same-sign operands producing an opposite-sign result.
                ovf      = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                result_o = diff;
                // Opposite-sign operands where the result leaves A's sign.
                ovf      = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SLL: result_o = a_i << shamt;
            ALU_SRA: result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
    end

    always_comb begin
        flags_o      = '0;
        flags_o.ovf  = ovf;
        flags_o.neg  = result_o[MSB];
        flags_o.zero = (result_o == '0);
    end

endmodule

// File: rtl/exec_pipe.sv
// -----------------------------------------------------------------------------
// exec_pipe
// Two-stage elastic execute stage for the GATE datapath.
//   S1 captures A, the second ALU operand (B or immediate), the immediate and
//   the opcode. S2 captures the ALU result, the immediate and the flags.
// Parameters:
//   WIDTH : datapath width, power of two, >= 8
//   IMM_W : raw immediate width, 12 <= IMM_W <= WIDTH
// Ports:
//   CLK, reset             : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    : input handshake (in_ready is combinational
//                            from out_ready)
//   A, B                   : operands
//   din, numBits, immShift : raw immediate, field-size select, left shift
//   ALUOp, ALUSrcB         : operation, second-operand select (1 = immediate)
//   out_valid / out_ready  : output handshake
//   ALUOut, immGen, flags  : registered result, immediate, {ovf, neg, zero}
// -----------------------------------------------------------------------------
module exec_pipe
    import exec_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMM_W = 12
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [IMM_W-1:0]   din,
    input  logic [1:0]         numBits,
    input  logic [1:0]         immShift,
    input  logic [2:0]         ALUOp,
    input  logic               ALUSrcB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   ALUOut,
    output logic [WIDTH-1:0]   immGen,
    output logic [2:0]         flags
);

    // ---------------------------------------------------------------------
    // Immediate generation and operand select
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_gen;
    logic [WIDTH-1:0] op2;

    always_comb begin
        imm_sext = '0;
        unique case (numBits)
            NB_4:    imm_sext = {{(WIDTH-IMM_FW_4){din[IMM_FW_4-1]}},   din[IMM_FW_4-1:0]};
            NB_6:    imm_sext = {{(WIDTH-IMM_FW_6){din[IMM_FW_6-1]}},   din[IMM_FW_6-1:0]};
            NB_8:    imm_sext = {{(WIDTH-IMM_FW_8){din[IMM_FW_8-1]}},   din[IMM_FW_8-1:0]};
            NB_12:   imm_sext = {{(WIDTH-IMM_FW_12){din[IMM_FW_12-1]}}, din[IMM_FW_12-1:0]};
            default: imm_sext = '0;
        endcase
    end

    // Shift is applied after sign extension; bits pushed past WIDTH are lost.
    assign imm_gen = imm_sext << immShift;
    assign op2     = ALUSrcB ? imm_gen : B;

    // ---------------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_op2_q,   s1_op2_d;
    logic [WIDTH-1:0] s1_imm_q,   s1_imm_d;
    alu_op_e          s1_op_q,    s1_op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_alu_q,   s2_alu_d;
    logic [WIDTH-1:0] s2_imm_q,   s2_imm_d;
    flags_t           s2_flags_q, s2_flags_d;

    logic [WIDTH-1:0] alu_result;
    flags_t           alu_flags;

    exec_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i     (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_op2_q),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    // ---------------------------------------------------------------------
    // Handshake control
    // ---------------------------------------------------------------------
    logic s2_load;
    logic s1_take;

    // S2 can accept whenever it is empty or its content is leaving; S1 can
    // accept whenever it is empty or it is moving into S2. This chains
    // out_ready straight through to in_ready so a full pipe still streams.
    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign s1_take  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_op2_d   = s1_op2_q;
        s1_imm_d   = s1_imm_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_alu_d   = s2_alu_q;
        s2_imm_d   = s2_imm_q;
        s2_flags_d = s2_flags_q;

        // When S1 is free to change, its valid bit follows in_valid, so an
        // idle input lets S1 drain instead of re-issuing the old operation.
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (s1_take) begin
            s1_a_d   = A;
            s1_op2_d = op2;
            s1_imm_d = imm_gen;
            s1_op_d  = alu_op_e'(ALUOp);
        end

        // Result registers only change on a real S1->S2 move, which keeps
        // them stable while out_valid is held against out_ready=0.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load && s1_valid_q) begin
            s2_alu_d   = alu_result;
            s2_imm_d   = s1_imm_q;
            s2_flags_d = alu_flags;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    // NOTE: the data registers are reset as well as the valid bits, because
    // ALUOut/immGen/flags are architecturally required to read zero after reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_op2_q   <= '0;
            s1_imm_q   <= '0;
            s1_op_q    <= ALU_ADD;
            s2_valid_q <= 1'b0;
            s2_alu_q   <= '0;
            s2_imm_q   <= '0;
            s2_flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_op2_q   <= s1_op2_d;
            s1_imm_q   <= s1_imm_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_alu_q   <= s2_alu_d;
            s2_imm_q   <= s2_imm_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign out_valid = s2_valid_q;
    assign ALUOut    = s2_alu_q;
    assign immGen    = s2_imm_q;
    assign flags     = s2_flags_q;

endmodule

// File: tb/tb_exec_pipe.sv
// -----------------------------------------------------------------------------
// tb_exec_pipe
// Scoreboard bench for exec_pipe (WIDTH=16, IMM_W=12). The driver pushes the
// reference-model result for every accepted operation; an independent monitor
// pops and compares on every output transfer and checks that a stalled output
// holds its value.
// -----------------------------------------------------------------------------
module tb_exec_pipe;

    localparam int W  = 16;
    localparam int IW = 12;

    logic          CLK = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A, B;
    logic [IW-1:0] din;
    logic [1:0]    numBits, immShift;
    logic [2:0]    ALUOp;
    logic          ALUSrcB;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  ALUOut, immGen;
    logic [2:0]    flags;

    always #5 CLK = ~CLK;

    exec_pipe #(
        .WIDTH (W),
        .IMM_W (IW)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .din       (din),
        .numBits   (numBits),
        .immShift  (immShift),
        .ALUOp     (ALUOp),
        .ALUSrcB   (ALUSrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUOut    (ALUOut),
        .immGen    (immGen),
        .flags     (flags)
    );

    typedef struct {
        logic [W-1:0] alu;
        logic [W-1:0] imm;
        logic [2:0]   fl;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_pops = 0;
    bit   rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: integer arithmetic on the signed values, then wrap.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [IW-1:0] d, input logic [1:0] nb,
                                   input logic [1:0] sh, input logic [2:0] op,
                                   input logic src);
        exp_t         e;
        int           fw, iv, av, bv, r, amt;
        logic         ovf;
        logic [W-1:0] op2v;
        case (nb)
            2'd0:    fw = 4;
            2'd1:    fw = 6;
            2'd2:    fw = 8;
            default: fw = 12;
        endcase
        iv = int'(d) & ((1 << fw) - 1);
        if (iv >= (1 << (fw - 1))) iv = iv - (1 << fw);
        iv    = iv * (1 << int'(sh));
        e.imm = W'(iv);
        op2v  = src ? e.imm : b;
        av    = int'($signed(a));
        bv    = int'($signed(op2v));
        amt   = int'(op2v) % W;
        ovf   = 1'b0;
        case (op)
            3'd0: begin r = av + bv; ovf = (r > 32767) || (r < -32768); end
            3'd1: begin r = av - bv; ovf = (r > 32767) || (r < -32768); end
            3'd2: r = av & bv;
            3'd3: r = av | bv;
            3'd4: r = av ^ bv;
            3'd5: r = av * (1 << amt);
            3'd6: r = av >>> amt;
            default: r = (av < bv) ? 1 : 0;
        endcase
        e.alu = W'(r);
        e.fl  = {ovf, e.alu[W-1], (e.alu == '0)};
        return e;
    endfunction

    // Present one operation, wait (bounded) for acceptance, record expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [IW-1:0] d, input logic [1:0] nb,
                         input logic [1:0] sh, input logic [2:0] op,
                         input logic src, output int waited);
        A = a; B = b; din = d; numBits = nb; immShift = sh; ALUOp = op; ALUSrcB = src;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge CLK);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge CLK);
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", waited);
        end else begin
            sb.push_back(model(a, b, d, nb, sh, op, src));
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_rand(output int waited);
        logic [W-1:0] a, b;
        case ($urandom_range(0, 5))
            0:       a = 16'h7FFF;
            1:       a = 16'h8000;
            2:       a = 16'hFFFF;
            default: a = W'($urandom);
        endcase
        b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
        issue(a, b, IW'($urandom), 2'($urandom), 2'($urandom), 3'($urandom),
              1'($urandom), waited);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Monitor: compares every output transfer against the scoreboard and
    // checks that a stalled output does not change.
    initial begin
        exp_t e;
        exp_t held;
        bit   stalled;
        stalled = 1'b0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check("hold_valid", out_valid, 1);
                check("hold_alu",   ALUOut,    held.alu);
                check("hold_imm",   immGen,    held.imm);
                check("hold_flags", flags,     held.fl);
            end
            stalled = out_valid && !out_ready;
            if (stalled) begin
                held.alu = ALUOut;
                held.imm = immGen;
                held.fl  = flags;
            end
            if (out_valid && out_ready) begin
                n_pops++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_output: ALUOut=%0h with empty scoreboard", ALUOut);
                end else begin
                    e = sb.pop_front();
                    check("alu_out", ALUOut, e.alu);
                    check("imm_gen", immGen, e.imm);
                    check("flags",   flags,  e.fl);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;
        int pops0;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; din = '0; numBits = '0; immShift = '0; ALUOp = '0; ALUSrcB = 1'b0;
        rand_done = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_out",   ALUOut,    0);
        check("rst_imm_gen",   immGen,    0);
        check("rst_flags",     flags,     0);
        @(posedge CLK);
        #1;
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);

        // Single add and its two-edge latency
        out_ready = 1'b1;
        issue(16'd5, 16'hFFFD, '0, 2'd0, 2'd0, 3'd0, 1'b0, w);
        check("lat_after_edge1", out_valid, 0);
        idle(1);
        check("lat_after_edge2", out_valid, 1);
        check("lat_alu_out",     ALUOut,    2);
        check("lat_flags",       flags,     0);
        idle(2);

        // Immediate path, overflow, signed compare
        issue(16'd0,    16'd0, 12'h0F9, 2'd2, 2'd2, 3'd0, 1'b1, w);
        issue(16'h7FFF, 16'd1, '0,      2'd0, 2'd0, 3'd0, 1'b0, w);
        issue(16'hFFFF, 16'd1, '0,      2'd0, 2'd0, 3'd7, 1'b0, w);
        idle(4);

        // Back-pressure: two accepts fill the pipe, then ops 3 and 4 wait
        pops0     = n_pops;
        out_ready = 1'b0;
        issue_rand(w);
        issue_rand(w);
        check("bp_in_ready_full", in_ready, 0);
        fork
            begin
                issue_rand(w);
                issue_rand(w);
            end
            begin
                idle(3);
                out_ready = 1'b1;
            end
        join
        idle(4);
        check("bp_pops",    n_pops - pops0, 4);
        check("bp_drained", sb.size(),      0);

        // Full throughput: 10 back-to-back operations
        cnt = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    issue_rand(w);
                    check("tp_no_wait", w, 0);
                end
            end
            begin
                repeat (14) begin
                    @(negedge CLK);
                    if (out_valid) cnt++;
                end
            end
        join
        #1;
        check("tp_valid_cycles", cnt, 10);
        idle(2);

        // Randomized traffic with random back-pressure and idle gaps
        fork
            begin
                while (!rand_done) begin
                    @(posedge CLK);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    issue_rand(w);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rand_done = 1'b1;
            end
        join
        out_ready = 1'b1;
        idle(5);
        check("rand_drained", sb.size(), 0);

        // Mid-operation reset with both stages full
        out_ready = 1'b0;
        issue_rand(w);
        issue_rand(w);
        check("mr_full", in_ready, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        sb.delete();
        check("mr_out_valid", out_valid, 0);
        check("mr_in_ready",  in_ready,  1);
        check("mr_alu_out",   ALUOut,    0);
        check("mr_flags",     flags,     0);
        out_ready = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge CLK);
            if (out_valid) cnt++;
        end
        check("mr_no_stale", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
